mux_nx1_stream: RTL and testbench

- Parametrised successor to the 4:1 combinational mux.
- Selects one of N_CH streaming input channels onto a single registered output, using a valid/ready handshake.
- Two modes, fixed at elaboration:
  - MODE=0: external select.
  - MODE=1: round-robin arbitration among requesting channels.
- Sits between producer blocks and a shared downstream consumer; output is fully registered (one pipeline stage).

---
 rtl/mux_nx1_stream.sv | 104 ++++++++++
 tb/tb_mux_nx1_stream.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/mux_nx1_stream.sv
// mux_nx1_stream: N_CH-to-1 valid/ready stream mux (MODE 0 external select, MODE 1 round-robin) with a registered output stage; define MUX_NX1_STREAM_PKT_LOCK_EN for packet-locked grants with in_last/out_last
module mux_nx1_stream #(
   parameter int N_CH = 4,
   parameter int WIDTH = 8,
   parameter int MODE = 0,
   localparam int SEL_W = $clog2(N_CH)
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [N_CH*WIDTH-1:0] in_data,
   input  logic [N_CH-1:0]       in_valid,
   output logic [N_CH-1:0]       in_ready,
`ifdef MUX_NX1_STREAM_PKT_LOCK_EN
   input  logic [N_CH-1:0]       in_last,
   output logic                  out_last,
`endif
   input  logic [SEL_W-1:0]      sel,
   output logic [WIDTH-1:0]      out_data,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic [SEL_W-1:0]      out_ch
);
   if (MODE != 0 && MODE != 1) begin : g_bad_mode
      $error("mux_nx1_stream: MODE must be 0 or 1");
   end
   if (N_CH < 2 || N_CH > 16) begin : g_bad_nch
      $error("mux_nx1_stream: N_CH must be in 2..16");
   end
   logic             load, xfer, rr_ok, gnt_ok;
   logic [SEL_W-1:0] rr_gnt, gnt;
   logic [WIDTH-1:0] g_data;
   logic             out_valid_q, out_valid_d;
   logic [WIDTH-1:0] out_data_q, out_data_d;
   logic [SEL_W-1:0] out_ch_q, out_ch_d, ptr_q, ptr_d;
`ifdef MUX_NX1_STREAM_PKT_LOCK_EN
   logic             g_last, lock_q, lock_d, out_last_q, out_last_d;
   logic [SEL_W-1:0] lock_ch_q, lock_ch_d;
   assign out_last = out_last_q;
`endif
   assign out_data  = out_data_q;
   assign out_valid = out_valid_q;
   assign out_ch    = out_ch_q;
   // Round-robin search: first valid channel after ptr_q, wrapping around
   always_comb begin
      rr_gnt = '0;
      rr_ok  = 1'b0;
      for (int k = 1; k <= N_CH; k++) begin
         if (!rr_ok && in_valid[(int'(ptr_q) + k) % N_CH]) begin
            rr_gnt = SEL_W'((int'(ptr_q) + k) % N_CH);
            rr_ok  = 1'b1;
         end
      end
   end
   // Grant, ready, beat selection and next state of the output stage
   always_comb begin
      load   = !out_valid_q || out_ready;
      gnt    = (MODE == 1) ? rr_gnt : sel;
      gnt_ok = (MODE == 1) ? rr_ok : ({1'b0, sel} < (SEL_W + 1)'(N_CH));
`ifdef MUX_NX1_STREAM_PKT_LOCK_EN
      gnt    = lock_q ? lock_ch_q : gnt;
      gnt_ok = lock_q || gnt_ok;
`endif
      in_ready = (gnt_ok && load && !rst) ? (N_CH'(1) << gnt) : '0;
      g_data   = '0;
      for (int i = 0; i < N_CH; i++) begin
         g_data = in_ready[i] ? in_data[i*WIDTH +: WIDTH] : g_data;
      end
      xfer        = |(in_valid & in_ready);
      out_valid_d = load ? xfer : out_valid_q;
      out_data_d  = xfer ? g_data : out_data_q;
      out_ch_d    = xfer ? gnt : out_ch_q;
      ptr_d       = xfer ? gnt : ptr_q;
`ifdef MUX_NX1_STREAM_PKT_LOCK_EN
      g_last     = |(in_last & in_ready);
      lock_d     = xfer ? !g_last : lock_q;
      lock_ch_d  = xfer ? gnt : lock_ch_q;
      out_last_d = xfer ? g_last : out_last_q;
`endif
   end
   // Output pipeline register, RR pointer and packet lock; reset drops any held beat
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         out_valid_q <= 1'b0;
         out_data_q  <= '0;
         out_ch_q    <= '0;
         ptr_q       <= SEL_W'(N_CH - 1);
`ifdef MUX_NX1_STREAM_PKT_LOCK_EN
         lock_q      <= 1'b0;
         lock_ch_q   <= '0;
         out_last_q  <= 1'b0;
`endif
      end else begin
         out_valid_q <= out_valid_d;
         out_data_q  <= out_data_d;
         out_ch_q    <= out_ch_d;
         ptr_q       <= ptr_d;
`ifdef MUX_NX1_STREAM_PKT_LOCK_EN
         lock_q      <= lock_d;
         lock_ch_q   <= lock_ch_d;
         out_last_q  <= out_last_d;
`endif
      end
   end
endmodule

// File: tb/tb_mux_nx1_stream.sv
// tb_mux_nx1_stream: self-checking bench for mux_nx1_stream in select mode (N_CH=4 and N_CH=3) and round-robin mode
module tb_mux_nx1_stream;
   logic        clk = 1'b0;
   logic        rst;
   logic [31:0] d0_data;
   logic [3:0]  d0_valid, d0_ready;
   logic [1:0]  d0_sel, d0_och;
   logic [7:0]  d0_odata;
   logic        d0_ovalid, d0_ordy;
   logic [31:0] d1_data;
   logic [3:0]  d1_valid, d1_ready;
   logic [1:0]  d1_sel, d1_och;
   logic [7:0]  d1_odata;
   logic        d1_ovalid, d1_ordy;
   logic [23:0] d2_data;
   logic [2:0]  d2_valid, d2_ready;
   logic [1:0]  d2_sel, d2_och;
   logic [7:0]  d2_odata;
   logic        d2_ovalid, d2_ordy;
`ifdef MUX_NX1_STREAM_PKT_LOCK_EN
   logic [3:0]  d0_last, d1_last;
   logic [2:0]  d2_last;
   logic        d0_olast, d1_olast, d2_olast;
`endif
   int vectors = 0;
   int miscompares = 0;
   int seq = 0;
   typedef struct {
      logic [1:0]  sel;
      logic [3:0]  vld;
      logic        ordy;
      logic [31:0] data;
      logic [3:0]  e_rdy;
      logic        e_ov;
      logic [7:0]  e_od;
      logic [1:0]  e_oc;
   } vec_t;
   typedef struct {
      logic [1:0] ch;
      logic [7:0] data;
      logic       last;
   } beat_t;
   vec_t  tbl[12];
   beat_t sb[$];

   always #5 clk = ~clk;

   mux_nx1_stream #(.N_CH(4), .WIDTH(8), .MODE(0)) u0 (
      .clk(clk), .rst(rst), .in_data(d0_data), .in_valid(d0_valid), .in_ready(d0_ready),
`ifdef MUX_NX1_STREAM_PKT_LOCK_EN
      .in_last(d0_last), .out_last(d0_olast),
`endif
      .sel(d0_sel), .out_data(d0_odata), .out_valid(d0_ovalid), .out_ready(d0_ordy), .out_ch(d0_och));

   mux_nx1_stream #(.N_CH(4), .WIDTH(8), .MODE(1)) u1 (
      .clk(clk), .rst(rst), .in_data(d1_data), .in_valid(d1_valid), .in_ready(d1_ready),
`ifdef MUX_NX1_STREAM_PKT_LOCK_EN
      .in_last(d1_last), .out_last(d1_olast),
`endif
      .sel(d1_sel), .out_data(d1_odata), .out_valid(d1_ovalid), .out_ready(d1_ordy), .out_ch(d1_och));

   mux_nx1_stream #(.N_CH(3), .WIDTH(8), .MODE(0)) u2 (
      .clk(clk), .rst(rst), .in_data(d2_data), .in_valid(d2_valid), .in_ready(d2_ready),
`ifdef MUX_NX1_STREAM_PKT_LOCK_EN
      .in_last(d2_last), .out_last(d2_olast),
`endif
      .sel(d2_sel), .out_data(d2_odata), .out_valid(d2_ovalid), .out_ready(d2_ordy), .out_ch(d2_och));

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   // One round-robin cycle: drive, check ready, push the expected beat if channel g transfers
   task automatic cyc1(input logic [3:0] vld, input logic [3:0] lst, input logic ordy,
                       input logic [3:0] e_rdy, input int g);
      beat_t b;
      seq++;
      d1_valid = vld;
      d1_ordy  = ordy;
`ifdef MUX_NX1_STREAM_PKT_LOCK_EN
      d1_last  = lst;
`endif
      for (int i = 0; i < 4; i++) d1_data[i*8 +: 8] = {seq[3:0], 4'(i)};
      #1 chk("rr_ready", 32'(d1_ready), 32'(e_rdy));
      if (g >= 0) begin
         b.ch   = 2'(g);
         b.data = {seq[3:0], 4'(g)};
         b.last = lst[g];
         sb.push_back(b);
      end
      @(posedge clk);
      #1;
   endtask

   // Scoreboard: a beat is consumed on the edge after a negedge that sees out_valid && out_ready
   always @(negedge clk) begin
      beat_t e;
      if (!rst && d1_ovalid && d1_ordy) begin
         if (sb.size() == 0) begin
            vectors++;
            miscompares++;
            $display("FAIL rr_unexpected: got beat ch=%0d data=0x%0h, expected none", d1_och, d1_odata);
         end else begin
            e = sb.pop_front();
            chk("rr_ch", 32'(d1_och), 32'(e.ch));
            chk("rr_data", 32'(d1_odata), 32'(e.data));
`ifdef MUX_NX1_STREAM_PKT_LOCK_EN
            chk("rr_last", 32'(d1_olast), 32'(e.last));
`endif
         end
      end
   end

   initial begin
      tbl[0]  = '{2'd2, 4'b0100, 1'b1, 32'h3CA51100, 4'b0100, 1'b1, 8'hA5, 2'd2};
      tbl[1]  = '{2'd2, 4'b0000, 1'b1, 32'h3CA51100, 4'b0100, 1'b0, 8'hA5, 2'd2};
      tbl[2]  = '{2'd1, 4'b0010, 1'b0, 32'h3CA55100, 4'b0010, 1'b1, 8'h51, 2'd1};
      tbl[3]  = '{2'd1, 4'b0010, 1'b0, 32'h3CA55200, 4'b0000, 1'b1, 8'h51, 2'd1};
      tbl[4]  = '{2'd1, 4'b0010, 1'b0, 32'h3CA55200, 4'b0000, 1'b1, 8'h51, 2'd1};
      tbl[5]  = '{2'd1, 4'b0010, 1'b0, 32'h3CA55200, 4'b0000, 1'b1, 8'h51, 2'd1};
      tbl[6]  = '{2'd1, 4'b0010, 1'b1, 32'h3CA55200, 4'b0010, 1'b1, 8'h52, 2'd1};
      tbl[7]  = '{2'd3, 4'b1000, 1'b1, 32'h3CA55200, 4'b1000, 1'b1, 8'h3C, 2'd3};
      tbl[8]  = '{2'd0, 4'b1111, 1'b0, 32'h3CA5520F, 4'b0000, 1'b1, 8'h3C, 2'd3};
      tbl[9]  = '{2'd0, 4'b1111, 1'b1, 32'h3CA5520F, 4'b0001, 1'b1, 8'h0F, 2'd0};
      tbl[10] = '{2'd2, 4'b1011, 1'b1, 32'h3CA5520F, 4'b0100, 1'b0, 8'h0F, 2'd0};
      tbl[11] = '{2'd2, 4'b0000, 1'b0, 32'h3CA5520F, 4'b0100, 1'b0, 8'h0F, 2'd0};
      rst = 1'b1;
      d0_data = '0; d0_valid = '0; d0_sel = '0; d0_ordy = 1'b0;
      d1_data = '0; d1_valid = 4'b1111; d1_sel = '0; d1_ordy = 1'b0;
      d2_data = '0; d2_valid = '0; d2_sel = '0; d2_ordy = 1'b0;
`ifdef MUX_NX1_STREAM_PKT_LOCK_EN
      d0_last = '1; d1_last = '1; d2_last = '1;
`endif
      repeat (2) @(posedge clk);
      #1;
      chk("rst_ovalid", 32'(d0_ovalid), 32'd0);
      chk("rst_odata", 32'(d0_odata), 32'd0);
      chk("rst_och", 32'(d0_och), 32'd0);
      chk("rst_ready_held", 32'(d1_ready), 32'd0);
      chk("rst_rr_ovalid", 32'(d1_ovalid), 32'd0);
      d1_valid = '0;
      rst = 1'b0;
      for (int n = 0; n < 12; n++) begin
         d0_sel   = tbl[n].sel;
         d0_valid = tbl[n].vld;
         d0_ordy  = tbl[n].ordy;
         d0_data  = tbl[n].data;
         #1 chk($sformatf("sel_v%0d_ready", n), 32'(d0_ready), 32'(tbl[n].e_rdy));
         @(posedge clk);
         #1;
         chk($sformatf("sel_v%0d_ovalid", n), 32'(d0_ovalid), 32'(tbl[n].e_ov));
         chk($sformatf("sel_v%0d_odata", n), 32'(d0_odata), 32'(tbl[n].e_od));
         chk($sformatf("sel_v%0d_och", n), 32'(d0_och), 32'(tbl[n].e_oc));
      end
      d2_sel = 2'd3; d2_valid = 3'b111; d2_ordy = 1'b1; d2_data = 24'h776655;
      #1 chk("n3_sel_oob_ready", 32'(d2_ready), 32'd0);
      @(posedge clk);
      #1 chk("n3_sel_oob_ovalid", 32'(d2_ovalid), 32'd0);
      d2_sel = 2'd2;
      #1 chk("n3_sel2_ready", 32'(d2_ready), 32'b100);
      @(posedge clk);
      #1;
      chk("n3_sel2_ovalid", 32'(d2_ovalid), 32'd1);
      chk("n3_sel2_odata", 32'(d2_odata), 32'h77);
      chk("n3_sel2_och", 32'(d2_och), 32'd2);
      for (int n = 0; n < 6; n++) cyc1(4'b1111, 4'hF, 1'b1, 4'(1 << (n % 4)), n % 4);
      for (int n = 0; n < 4; n++) cyc1(4'b1001, 4'hF, 1'b1, (n % 2 == 0) ? 4'b1000 : 4'b0001, (n % 2 == 0) ? 3 : 0);
      cyc1(4'b0000, 4'hF, 1'b1, 4'b0000, -1);
      cyc1(4'b0110, 4'hF, 1'b0, 4'b0010, 1);
      cyc1(4'b0110, 4'hF, 1'b0, 4'b0000, -1);
      cyc1(4'b0110, 4'hF, 1'b1, 4'b0100, 2);
      cyc1(4'b0000, 4'hF, 1'b1, 4'b0000, -1);
      cyc1(4'b1111, 4'hF, 1'b1, 4'b1000, 3);
      #1 rst = 1'b1;
      #1;
      chk("midrst_ovalid", 32'(d1_ovalid), 32'd0);
      chk("midrst_och", 32'(d1_och), 32'd0);
      chk("midrst_ready", 32'(d1_ready), 32'd0);
      sb.delete();
      @(posedge clk);
      #1 rst = 1'b0;
      cyc1(4'b1111, 4'hF, 1'b1, 4'b0001, 0);
      cyc1(4'b0000, 4'hF, 1'b1, 4'b0000, -1);
`ifdef MUX_NX1_STREAM_PKT_LOCK_EN
      cyc1(4'b0111, 4'b1111, 1'b1, 4'b0010, 1);
      cyc1(4'b0111, 4'b1101, 1'b1, 4'b0100, 2);
      cyc1(4'b0111, 4'b1011, 1'b1, 4'b0001, 0);
      cyc1(4'b0111, 4'b1101, 1'b1, 4'b0010, 1);
      cyc1(4'b0101, 4'b1101, 1'b1, 4'b0010, -1);
      cyc1(4'b0111, 4'b1101, 1'b1, 4'b0010, 1);
      cyc1(4'b0111, 4'b1111, 1'b1, 4'b0010, 1);
      cyc1(4'b0111, 4'b1111, 1'b1, 4'b0100, 2);
      cyc1(4'b0111, 4'b1111, 1'b1, 4'b0001, 0);
      cyc1(4'b0000, 4'b1111, 1'b1, 4'b0000, -1);
`endif
      repeat (2) @(posedge clk);
      #1 chk("sb_drained", 32'(sb.size()), 32'd0);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
